// File: rtl/rv32i_irom_pkg.sv
// Shared types and default sizes for the two-requester instruction-ROM arbiter.
package rv32i_irom_pkg;

   localparam int AWIDTH_DEF = 13;
   localparam int DWIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRESH = 2'd1,
      HELD  = 2'd2
   } slot_state_t;

endpackage

// File: rtl/rv32i_irom_rsp_slot.sv
// One response slot: presents ROM data the cycle after a grant and keeps it
// in a hold register while the requester stalls.
module rv32i_irom_rsp_slot
   import rv32i_irom_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              gnt,
   input  logic              misaligned,
   input  logic              rready,
   input  logic [DWIDTH-1:0] rom_q,
   output logic              rvalid,
   output logic [DWIDTH-1:0] rdata,
   output logic              err
);

   slot_state_t       state;
   slot_state_t       state_next;
   logic              err_flag;
   logic [DWIDTH-1:0] hold;
   logic [DWIDTH-1:0] fresh_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         err_flag <= 1'b0;
      end else begin
         state <= state_next;
         if (gnt) begin
            err_flag <= misaligned;
         end
      end
   end

   // The ROM output only lives one cycle, so a stalled FRESH response is captured here.
   always_ff @(posedge clock) begin
      if (state == FRESH && !rready) begin
         hold <= fresh_data;
      end
   end

   always_comb begin
      state_next = state;
      rvalid     = 1'b0;
      rdata      = '0;
      err        = 1'b0;
      fresh_data = err_flag ? '0 : rom_q;
      case (state)
         IDLE: begin
            if (gnt) begin
               state_next = FRESH;
            end
         end
         FRESH: begin
            rvalid = 1'b1;
            rdata  = fresh_data;
            err    = err_flag;
            if (rready) begin
               state_next = gnt ? FRESH : IDLE;
            end else begin
               state_next = HELD;
            end
         end
         HELD: begin
            rvalid = 1'b1;
            rdata  = hold;
            err    = err_flag;
            if (rready) begin
               state_next = gnt ? FRESH : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (reset) begin
         rvalid = 1'b0;
         rdata  = '0;
         err    = 1'b0;
      end
   end

endmodule

// File: rtl/rv32i_irom_arbiter.sv
// Two-requester arbiter for a single registered-output instruction ROM port.
// Define IROM_ARB_RR_EN for round-robin conflict resolution; default is fixed m0 priority.
module rv32i_irom_arbiter
   import rv32i_irom_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic [AWIDTH+1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DWIDTH-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m0_rready,
   input  logic              m1_req,
   input  logic [AWIDTH+1:0] m1_addr,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DWIDTH-1:0] m1_rdata,
   output logic              m1_err,
   input  logic              m1_rready,
   output logic [AWIDTH-1:0] rom_addr,
   input  logic [DWIDTH-1:0] rom_q
);

   logic elig0;
   logic elig1;
   logic pick1;

`ifdef IROM_ARB_RR_EN
   // Last-granted requester; resets to m1 so that m0 wins the first conflict.
   logic last_gnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (m0_gnt) begin
         last_gnt <= 1'b0;
      end else if (m1_gnt) begin
         last_gnt <= 1'b1;
      end
   end
`endif

   always_comb begin
      elig0 = m0_req && (!m0_rvalid || m0_rready);
      elig1 = m1_req && (!m1_rvalid || m1_rready);
`ifdef IROM_ARB_RR_EN
      pick1 = elig1 && (!elig0 || !last_gnt);
`else
      pick1 = elig1 && !elig0;
`endif
      m1_gnt   = !reset && pick1;
      m0_gnt   = !reset && elig0 && !pick1;
      rom_addr = m1_gnt ? m1_addr[AWIDTH+1:2] : m0_addr[AWIDTH+1:2];
   end

   rv32i_irom_rsp_slot #(
      .DWIDTH(DWIDTH)
   ) u_slot0 (
      .clock      (clock),
      .reset      (reset),
      .gnt        (m0_gnt),
      .misaligned (m0_addr[1:0] != 2'b00),
      .rready     (m0_rready),
      .rom_q      (rom_q),
      .rvalid     (m0_rvalid),
      .rdata      (m0_rdata),
      .err        (m0_err)
   );

   rv32i_irom_rsp_slot #(
      .DWIDTH(DWIDTH)
   ) u_slot1 (
      .clock      (clock),
      .reset      (reset),
      .gnt        (m1_gnt),
      .misaligned (m1_addr[1:0] != 2'b00),
      .rready     (m1_rready),
      .rom_q      (rom_q),
      .rvalid     (m1_rvalid),
      .rdata      (m1_rdata),
      .err        (m1_err)
   );

endmodule
